// File: rtl/prescaled_mod_counter.sv
// prescaled_mod_counter
//   Modulo-COUNT_TO up/down counter driven by an internal prescaler. Everything
//   runs on clk; the prescaler only produces a one-cycle enable (tick), so
//   stages cascade by feeding carry into the next stage's en (PRESCALE=1).
//
//   Optional feature macro: PRESCALED_MOD_COUNTER_BCD_EN
//     adds bcd_out = {tens, ones} of out, registered alongside out.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-low reset
//   en       in   prescaler / count enable
//   up_dn    in   1 = count up, 0 = count down
//   clr      in   synchronous clear (highest priority)
//   load     in   synchronous parallel load (saturates at COUNT_TO-1)
//   load_val in   load value
//   out      out  count register, 0..COUNT_TO-1
//   tick     out  combinational prescaler tick
//   carry    out  registered one-cycle wrap pulse, coincident with wrapped out
//   bcd_out  out  (BCD build only) two BCD digits of out

module prescaled_mod_counter #(
    parameter int WIDTH    = 7,
    parameter int COUNT_TO = 60,
    parameter int PRESCALE = 100,
    parameter int PS_WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tick,
    output logic             carry
`ifdef PRESCALED_MOD_COUNTER_BCD_EN
    ,
    output logic [7:0]       bcd_out
`endif
);

    // Elaboration-time parameter checks
    if (COUNT_TO < 2 || COUNT_TO > 2**WIDTH) begin : g_bad_count_to
        $error("prescaled_mod_counter: COUNT_TO=%0d outside 2..2**WIDTH", COUNT_TO);
    end
    if (PRESCALE < 1 || PRESCALE - 1 >= 2**PS_WIDTH) begin : g_bad_prescale
        $error("prescaled_mod_counter: PRESCALE=%0d illegal for PS_WIDTH=%0d", PRESCALE, PS_WIDTH);
    end
`ifdef PRESCALED_MOD_COUNTER_BCD_EN
    if (COUNT_TO > 100) begin : g_bad_bcd
        $error("prescaled_mod_counter: BCD output needs COUNT_TO <= 100 (got %0d)", COUNT_TO);
    end
`endif

    localparam logic [WIDTH-1:0]    TOP     = WIDTH'(COUNT_TO - 1);
    localparam logic [WIDTH:0]      MODULUS = (WIDTH+1)'(COUNT_TO);
    localparam logic [PS_WIDTH-1:0] PS_TOP  = PS_WIDTH'(PRESCALE - 1);

    logic [PS_WIDTH-1:0] ps_cnt, ps_nxt;
    logic [WIDTH-1:0]    out_nxt;
    logic                carry_nxt;

    assign tick = en && (ps_cnt == PS_TOP);

    // Next-state: clr > load > tick count. Wrap is by compare against TOP,
    // so COUNT_TO == 2**WIDTH needs no overflow special case.
    always_comb begin
        ps_nxt    = ps_cnt;
        out_nxt   = out;
        carry_nxt = 1'b0;
        if (clr) begin
            ps_nxt  = '0;
            out_nxt = '0;
        end else if (load) begin
            ps_nxt  = '0;
            out_nxt = ({1'b0, load_val} < MODULUS) ? load_val : TOP;
        end else if (en) begin
            ps_nxt = (ps_cnt == PS_TOP) ? '0 : ps_cnt + PS_WIDTH'(1);
            if (tick) begin
                if (up_dn) begin
                    if (out == TOP) begin
                        out_nxt   = '0;
                        carry_nxt = 1'b1;
                    end else begin
                        out_nxt = out + WIDTH'(1);
                    end
                end else begin
                    if (out == '0) begin
                        out_nxt   = TOP;
                        carry_nxt = 1'b1;
                    end else begin
                        out_nxt = out - WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_cnt <= '0;
            out    <= '0;
            carry  <= 1'b0;
        end else begin
            ps_cnt <= ps_nxt;
            out    <= out_nxt;
            carry  <= carry_nxt;
        end
    end

`ifdef PRESCALED_MOD_COUNTER_BCD_EN
    // Encoded from out_nxt so the digits land on the same edge as out.
    function automatic logic [7:0] to_bcd(input logic [WIDTH-1:0] v);
        int unsigned x;
        x = 32'(v);
        return {4'(x / 10), 4'(x % 10)};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) bcd_out <= 8'h00;
        else      bcd_out <= to_bcd(out_nxt);
    end
`endif

endmodule

// File: tb/tb_prescaled_mod_counter.sv
module tb_prescaled_mod_counter;

    localparam int W = 4;
    localparam int N = 10;
    localparam int P = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en, up_dn, clr, load;
    logic [W-1:0] load_val;
    logic [W-1:0] out;
    logic         tick, carry;

    // cascade pair: seconds-like stage feeding a minutes-like stage
    logic         casc_rst;
    logic [5:0]   c1_out, c2_out;
    logic         c1_tick, c1_carry, c2_tick, c2_carry;
`ifdef PRESCALED_MOD_COUNTER_BCD_EN
    logic [7:0]   bcd_out, c1_bcd, c2_bcd;
`endif

    always #5 clk = ~clk;

    prescaled_mod_counter #(.WIDTH(W), .COUNT_TO(N), .PRESCALE(P), .PS_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .out(out), .tick(tick), .carry(carry)
`ifdef PRESCALED_MOD_COUNTER_BCD_EN
        , .bcd_out(bcd_out)
`endif
    );

    prescaled_mod_counter #(.WIDTH(6), .COUNT_TO(60), .PRESCALE(2), .PS_WIDTH(2)) c1 (
        .clk(clk), .rst(casc_rst), .en(1'b1), .up_dn(1'b1), .clr(1'b0), .load(1'b0),
        .load_val(6'd0), .out(c1_out), .tick(c1_tick), .carry(c1_carry)
`ifdef PRESCALED_MOD_COUNTER_BCD_EN
        , .bcd_out(c1_bcd)
`endif
    );

    prescaled_mod_counter #(.WIDTH(6), .COUNT_TO(60), .PRESCALE(1), .PS_WIDTH(1)) c2 (
        .clk(clk), .rst(casc_rst), .en(c1_carry), .up_dn(1'b1), .clr(1'b0), .load(1'b0),
        .load_val(6'd0), .out(c2_out), .tick(c2_tick), .carry(c2_carry)
`ifdef PRESCALED_MOD_COUNTER_BCD_EN
        , .bcd_out(c2_bcd)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        int out;
        int carry;
        int bcd;
    } st_t;

    st_t st_q[$];
    bit  tick_q[$];

    int m_ps, m_out, m_carry;

    function automatic int bcd_of(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    // Drive one cycle of inputs (called at posedge+2), predict tick for the
    // coming edge and the state just after it, then advance to next posedge+2.
    task automatic step(input bit e, input bit u, input bit c, input bit l, input int lv);
        bit t;
        en = e; up_dn = u; clr = c; load = l; load_val = W'(lv);
        t = e && (m_ps == P - 1);
        tick_q.push_back(t);
        m_carry = 0;
        if (c) begin
            m_out = 0; m_ps = 0;
        end else if (l) begin
            m_out = (lv < N) ? lv : N - 1;
            m_ps  = 0;
        end else if (e) begin
            m_ps = (m_ps + 1) % P;
            if (t) begin
                if (u) begin
                    m_carry = (m_out == N - 1);
                    m_out   = (m_out + 1) % N;
                end else begin
                    m_carry = (m_out == 0);
                    m_out   = (m_out + N - 1) % N;
                end
            end
        end
        st_q.push_back('{m_out, m_carry, bcd_of(m_out)});
        @(posedge clk);
        #2;
    endtask

    // Asynchronous reset pulse in mid-cycle: outputs must clear without an edge.
    task automatic do_rst();
        rst = 1'b0;
        #1;
        chk("async_rst_out", int'(out), 0);
        chk("async_rst_carry", int'(carry), 0);
        chk("async_rst_tick", int'(tick), 0);
        m_out = 0; m_ps = 0; m_carry = 0;
        #1;
        rst = 1'b1;
        step(0, 1, 0, 0, 0);
    endtask

    // monitors
    initial begin
        forever begin
            @(negedge clk);
            if (tick_q.size() > 0) begin
                bit t;
                t = tick_q.pop_front();
                chk("tick", int'(tick), int'(t));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (st_q.size() > 0) begin
                st_t s;
                s = st_q.pop_front();
                chk("out", int'(out), s.out);
                chk("carry", int'(carry), s.carry);
`ifdef PRESCALED_MOD_COUNTER_BCD_EN
                chk("bcd_out", int'(bcd_out), s.bcd);
`endif
            end
        end
    end

    // watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    // ---------------- main stimulus ----------------
    task automatic main_seq();
        rst = 1'b0; en = 1'b1; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
        m_out = 0; m_ps = 0; m_carry = 0;
        #1;
        chk("reset_out", int'(out), 0);
        chk("reset_carry", int'(carry), 0);
        chk("reset_tick", int'(tick), 0);
        @(posedge clk);
        #2;
        rst = 1'b1;

        // up count: 40 clocks, one wrap
        repeat (40) step(1, 1, 0, 0, 0);

        // down from 0: first tick wraps to N-1 with carry
        do_rst();
        repeat (8) step(1, 0, 0, 0, 0);

        // enable dropped at ps_cnt=2 for 5 cycles
        do_rst();
        repeat (2) step(1, 1, 0, 0, 0);
        repeat (5) step(0, 1, 0, 0, 0);
        repeat (4) step(1, 1, 0, 0, 0);

        // load coincident with a tick, then a saturating load
        while (m_ps != P - 1) step(1, 1, 0, 0, 0);
        step(1, 1, 0, 1, 7);
        repeat (3) step(1, 1, 0, 0, 0);
        step(1, 1, 0, 1, 12);
        repeat (2) step(1, 1, 0, 0, 0);

        // clr beats load
        step(1, 1, 0, 1, 5);
        step(1, 1, 1, 1, 3);
        repeat (2) step(1, 1, 0, 0, 0);

        // async reset with the prescaler mid-count
        do_rst();
        repeat (2) step(1, 1, 0, 0, 0);
        do_rst();

        // randomized mix
        for (int i = 0; i < 2000; i++) begin
            bit e, u, c, l;
            e = ($urandom % 8) != 0;
            u = (i / 64) % 2 == 0 ? (($urandom % 10) != 0) : (($urandom % 10) == 0);
            c = ($urandom % 50) == 0;
            l = ($urandom % 30) == 0;
            step(e, u, c, l, int'($urandom % 16));
        end
        en = 1'b0; clr = 1'b0; load = 1'b0;
        @(posedge clk);
        #3;
        chk("queues_drained", st_q.size() + tick_q.size(), 0);
    endtask

    // cascade: expectations from elapsed enabled edges with plain arithmetic
    task automatic casc_seq();
        int ticks, prev_ticks;
        casc_rst = 1'b0;
        @(posedge clk);
        #2;
        casc_rst = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk);
            #1;
            ticks      = k / 2;
            prev_ticks = (k - 1) / 2;
            chk("c1_out", int'(c1_out), ticks % 60);
            chk("c1_carry", int'(c1_carry), int'((k % 2 == 0) && ticks > 0 && ticks % 60 == 0));
            chk("c2_out", int'(c2_out), (prev_ticks / 60) % 60);
            chk("c2_carry", int'(c2_carry), 0);
`ifdef PRESCALED_MOD_COUNTER_BCD_EN
            chk("c1_bcd", int'(c1_bcd), bcd_of(ticks % 60));
`endif
        end
    endtask

    initial begin
        fork
            main_seq();
            casc_seq();
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
